// File: rtl/signed_add_arbiter.sv
// Round-robin sequencer that shares one external combinational signed adder among NREQ requesters.
// Optional macro SIGNED_ADD_SAT_EN clamps overflowing sums instead of wrapping them.
module signed_add_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH-1:0]      add_sum,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_ovf
);

  typedef enum logic [1:0] {IDLE, GRANT, EXEC, RESP} state_t;

  state_t                  state_q;
  logic [IDW-1:0]          grant_q;
  logic [IDW-1:0]          last_grant_q;
  logic [NREQ-1:0]         req_ready_q;
  logic signed [WIDTH-1:0] add_a_q;
  logic signed [WIDTH-1:0] add_b_q;
  logic                    rsp_valid_q;
  logic [IDW-1:0]          rsp_id_q;
  logic signed [WIDTH-1:0] rsp_sum_q;
  logic                    rsp_ovf_q;

  logic [IDW-1:0]          winner_d;
  logic [IDW-1:0]          cand;
  logic                    any_d;
  logic signed [WIDTH-1:0] sum_raw;
  logic signed [WIDTH-1:0] sum_d;
  logic                    ovf_d;

  function automatic logic ovf_f(input logic signed [WIDTH-1:0] a,
                                 input logic signed [WIDTH-1:0] b,
                                 input logic signed [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

`ifdef SIGNED_ADD_SAT_EN
  // Overflow only happens with equal operand signs, so a's sign picks the rail.
  function automatic logic signed [WIDTH-1:0] sat_f(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] s,
                                                    input logic                    ovf);
    if (!ovf) return s;
    return a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  assign sum_raw = add_sum;
  assign ovf_d   = ovf_f(add_a_q, add_b_q, sum_raw);
`ifdef SIGNED_ADD_SAT_EN
  assign sum_d   = sat_f(add_a_q, sum_raw, ovf_d);
`else
  assign sum_d   = sum_raw;
`endif

  // Search starts one past the previous winner so every valid requester gets a turn.
  always_comb begin
    winner_d = last_grant_q;
    any_d    = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant_q) + k) % NREQ);
      if (!any_d && req_valid[cand]) begin
        winner_d = cand;
        any_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      req_ready_q  <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_sum_q    <= '0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_d) begin
            grant_q     <= winner_d;
            req_ready_q <= NREQ'(1) << winner_d;
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          add_a_q      <= req_a[int'(grant_q)*WIDTH +: WIDTH];
          add_b_q      <= req_b[int'(grant_q)*WIDTH +: WIDTH];
          rsp_id_q     <= grant_q;
          last_grant_q <= grant_q;
          req_ready_q  <= '0;
          state_q      <= EXEC;
        end
        EXEC: begin
          rsp_sum_q   <= sum_d;
          rsp_ovf_q   <= ovf_d;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_valid_q && rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_signed_add_arbiter.sv
// Testbench for signed_add_arbiter: directed scenarios plus randomized traffic against a cycle-level model.
module tb_signed_add_arbiter;
  localparam int W  = 4;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*W-1:0]  req_a, req_b;
  logic [W-1:0]    add_a, add_b, add_sum;
  logic            rsp_valid, rsp_ready, rsp_ovf;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_sum;

  logic [N-1:0]    va;
  logic [W-1:0]    aa [N];
  logic [W-1:0]    bb [N];

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  assign req_valid = va;
  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = aa[i];
      req_b[i*W +: W] = bb[i];
    end
  end

  // The shared adder lives outside the arbiter.
  assign add_sum = add_a + add_b;

  signed_add_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ovf(rsp_ovf)
  );

  function automatic void model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] s, output logic o);
    int sa, sb, t;
    sa = $signed(a);
    sb = $signed(b);
    t  = sa + sb;
    o  = (t > 2**(W-1) - 1) || (t < -(2**(W-1)));
`ifdef SIGNED_ADD_SAT_EN
    if (o) t = (t > 0) ? 2**(W-1) - 1 : -(2**(W-1));
`endif
    s = t[W-1:0];
  endfunction

  function automatic int model_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic do_reset();
    va  = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Raises one request and records what the DUT shows at grant, T+1, T+2 and T+3.
  task automatic issue_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [N-1:0] rr, output logic v1, output logic v2,
                          output logic v3, output logic [IW-1:0] rid,
                          output logic [W-1:0] rsum, output logic rovf);
    bit got;
    got = 1'b0;
    rr  = '0;
    va[id] = 1'b1; aa[id] = a; bb[id] = b;
    for (int n = 0; n < 12 && !got; n++) begin
      @(negedge clk);
      if (req_ready !== '0) begin got = 1'b1; rr = req_ready; end
      @(posedge clk); #1;
    end
    va[id] = 1'b0;
    @(negedge clk); v1 = rsp_valid;
    @(posedge clk); #1;
    @(negedge clk); v2 = rsp_valid; rid = rsp_id; rsum = rsp_sum; rovf = rsp_ovf;
    @(posedge clk); #1;
    @(negedge clk); v3 = rsp_valid;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    va = '0; rsp_ready = 1'b0; rst = 1'b1;
    for (int i = 0; i < N; i++) begin aa[i] = '0; bb[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    vec++;
    if ({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf, add_a, add_b} !== '0) begin
      $display("FAIL reset_values got rr=%b v=%b id=%0d sum=%h ovf=%b a=%h b=%h exp all zero",
               req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf, add_a, add_b);
      errs++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vec++;
      if (req_ready !== '0 || rsp_valid !== 1'b0) begin
        $display("FAIL idle_quiet got rr=%b v=%b exp rr=0 v=0", req_ready, rsp_valid);
        errs++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] ta [4] = '{4'd3, 4'd7, 4'h8, 4'hD};
    logic [W-1:0] tb [4] = '{4'd2, 4'd1, 4'hF, 4'd5};
`ifdef SIGNED_ADD_SAT_EN
    logic [W-1:0] ts [4] = '{4'd5, 4'h7, 4'h8, 4'd2};
`else
    logic [W-1:0] ts [4] = '{4'd5, 4'h8, 4'h7, 4'd2};
`endif
    logic         to [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [N-1:0] rr;
    logic         v1, v2, v3, rovf;
    logic [IW-1:0] rid;
    logic [W-1:0] rsum;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue_op(i, ta[i], tb[i], rr, v1, v2, v3, rid, rsum, rovf);
      vec++;
      if (rr !== (N'(1) << i)) begin
        $display("FAIL basic_grant case=%0d got=%b exp=%b", i, rr, N'(1) << i); errs++;
      end
      vec++;
      if (v1 !== 1'b0) begin $display("FAIL basic_early_valid case=%0d got=%b exp=0", i, v1); errs++; end
      vec++;
      if (v2 !== 1'b1 || rid !== IW'(i) || rsum !== ts[i] || rovf !== to[i]) begin
        $display("FAIL basic_rsp case=%0d got v=%b id=%0d sum=%h ovf=%b exp v=1 id=%0d sum=%h ovf=%b",
                 i, v2, rid, rsum, rovf, i, ts[i], to[i]);
        errs++;
      end
      vec++;
      if (v3 !== 1'b0) begin $display("FAIL basic_one_cycle_rsp case=%0d got=%b exp=0", i, v3); errs++; end
    end
  endtask

  task automatic test_fairness();
    int order[$];
    int expo [6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin va[i] = 1'b1; aa[i] = W'(i); bb[i] = W'(1); end
    for (int n = 0; n < 60 && order.size() < 6; n++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) order.push_back(i);
      @(posedge clk); #1;
    end
    vec++;
    if (order.size() != 6) begin $display("FAIL fair_count got=%0d exp=6", order.size()); errs++; end
    for (int k = 0; k < order.size() && k < 6; k++) begin
      vec++;
      if (order[k] != expo[k]) begin
        $display("FAIL fair_order idx=%0d got=%0d exp=%0d", k, order[k], expo[k]); errs++;
      end
    end
    va = '0;
  endtask

  task automatic test_backpressure();
    bit got;
    do_reset();
    rsp_ready = 1'b0;
    va[1] = 1'b1; aa[1] = 4'd5; bb[1] = 4'd1;
    got = 1'b0;
    for (int n = 0; n < 12 && !got; n++) begin
      @(negedge clk);
      if (req_ready !== '0) got = 1'b1;
      @(posedge clk); #1;
    end
    vec++;
    if (!got) begin $display("FAIL bp_grant1 got=none exp=0010"); errs++; end
    va[1] = 1'b0;
    va[2] = 1'b1; aa[2] = 4'd1; bb[2] = 4'd1;
    @(posedge clk); #1;
    repeat (5) begin
      @(negedge clk);
      vec++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 4'd6 || rsp_ovf !== 1'b0 || req_ready !== '0) begin
        $display("FAIL bp_stall got v=%b id=%0d sum=%h ovf=%b rr=%b exp v=1 id=1 sum=6 ovf=0 rr=0",
                 rsp_valid, rsp_id, rsp_sum, rsp_ovf, req_ready);
        errs++;
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    vec++;
    if (rsp_valid !== 1'b1) begin $display("FAIL bp_accept_cycle got v=%b exp=1", rsp_valid); errs++; end
    @(posedge clk); #1;
    @(negedge clk);
    vec++;
    if (rsp_valid !== 1'b0 || req_ready !== '0) begin
      $display("FAIL bp_done got v=%b rr=%b exp v=0 rr=0", rsp_valid, req_ready); errs++;
    end
    @(posedge clk); #1;
    @(negedge clk);
    vec++;
    if (req_ready !== 4'b0100) begin $display("FAIL bp_grant2 got=%b exp=0100", req_ready); errs++; end
    @(posedge clk); #1;
    va = '0;
  endtask

  task automatic test_reset_midop();
    bit got;
    do_reset();
    rsp_ready = 1'b1;
    va[1] = 1'b1; aa[1] = 4'd2; bb[1] = 4'd3;
    got = 1'b0;
    for (int n = 0; n < 12 && !got; n++) begin
      @(negedge clk);
      if (req_ready !== '0) got = 1'b1;
      if (!got) begin @(posedge clk); #1; end
    end
    vec++;
    if (req_ready !== 4'b0010) begin $display("FAIL mid_grant got=%b exp=0010", req_ready); errs++; end
    @(posedge clk); #1;
    va[1] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    va[0] = 1'b1; aa[0] = 4'd1; bb[0] = 4'd1;
    va[2] = 1'b1; aa[2] = 4'd1; bb[2] = 4'd2;
    @(negedge clk);
    vec++;
    if ({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf, add_a, add_b} !== '0) begin
      $display("FAIL mid_reset_values got rr=%b v=%b id=%0d sum=%h ovf=%b a=%h b=%h exp all zero",
               req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf, add_a, add_b);
      errs++;
    end
    @(posedge clk); #1;
    @(negedge clk);
    vec++;
    if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin
      $display("FAIL mid_next_grant got rr=%b v=%b exp rr=0001 v=0", req_ready, rsp_valid); errs++;
    end
    @(posedge clk); #1;
    va = '0;
  endtask

  task automatic test_random();
    int cyc, idle_cyc, gnt_cyc, rsp_cyc, last_m, win, drop, done;
    logic [N-1:0]  exp_rr;
    logic [IW-1:0] q_id[$];
    logic [W-1:0]  q_sum[$];
    logic          q_ovf[$];
    logic [W-1:0]  es;
    logic          eo;
    do_reset();
    last_m = N - 1; cyc = 0; idle_cyc = 0; gnt_cyc = -1; rsp_cyc = 0; done = 0; win = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      va[i] = 1'($urandom_range(0, 1)); aa[i] = W'($urandom); bb[i] = W'($urandom);
    end
    repeat (800) begin
      drop = -1;
      @(negedge clk);
      exp_rr = (cyc == gnt_cyc) ? (N'(1) << win) : '0;
      vec++;
      if (req_ready !== exp_rr) begin
        $display("FAIL rand_req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rr); errs++;
      end
      if (cyc == gnt_cyc) begin
        model_add(aa[win], bb[win], es, eo);
        q_id.push_back(IW'(win)); q_sum.push_back(es); q_ovf.push_back(eo);
        rsp_cyc = cyc + 2; last_m = win; drop = win;
      end
      if (q_id.size() > 0 && cyc >= rsp_cyc) begin
        vec++;
        if (rsp_valid !== 1'b1 || rsp_id !== q_id[0] || rsp_sum !== q_sum[0] || rsp_ovf !== q_ovf[0]) begin
          $display("FAIL rand_rsp cyc=%0d got v=%b id=%0d sum=%h ovf=%b exp v=1 id=%0d sum=%h ovf=%b",
                   cyc, rsp_valid, rsp_id, rsp_sum, rsp_ovf, q_id[0], q_sum[0], q_ovf[0]);
          errs++;
        end
        if (rsp_ready) begin
          void'(q_id.pop_front()); void'(q_sum.pop_front()); void'(q_ovf.pop_front());
          idle_cyc = cyc + 1; done++;
        end
      end else begin
        vec++;
        if (rsp_valid !== 1'b0) begin $display("FAIL rand_spurious_rsp cyc=%0d got=%b exp=0", cyc, rsp_valid); errs++; end
      end
      if (cyc == idle_cyc) begin
        if (|va) begin win = model_pick(va, last_m); gnt_cyc = cyc + 1; end
        else idle_cyc = cyc + 1;
      end
      @(posedge clk); #1;
      cyc++;
      if (drop >= 0) va[drop] = 1'b0;
      for (int i = 0; i < N; i++)
        if (!va[i] && $urandom_range(0, 2) == 0) begin
          va[i] = 1'b1; aa[i] = W'($urandom); bb[i] = W'($urandom);
        end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    vec++;
    if (done < 40) begin $display("FAIL rand_throughput got=%0d exp>=40", done); errs++; end
    va = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fairness();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
